// File: rtl/spad_iact_window.sv
// Input-activation scratchpad: captures an act_size x act_size plane from the router
// and replays it as stride-1 kernel_size x kernel_size windows over valid/ready.
module spad_iact_window #(
    parameter int DATA_BITWIDTH      = 16,
    parameter int ADDR_BITWIDTH_SPAD = 9,
    parameter int act_size           = 5,
    parameter int kernel_size        = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_BITWIDTH-1:0] w_data_spad,
    input  logic                     load_en_spad,
    output logic                     load_done,
    input  logic                     start_conv,
    output logic [DATA_BITWIDTH-1:0] iact_out,
    output logic                     iact_valid,
    input  logic                     iact_ready,
    output logic                     win_last,
    output logic                     conv_done,
    output logic                     busy
);

    localparam int AW = ADDR_BITWIDTH_SPAD;
    localparam logic [AW-1:0] ACT_A = AW'(act_size);
    localparam logic [AW-1:0] KM1   = AW'(kernel_size - 1);
    localparam logic [AW-1:0] OM1   = AW'(act_size - kernel_size);
    localparam logic [AW-1:0] NM1   = AW'(act_size * act_size - 1);

    typedef enum logic [1:0] {IDLE, LOADING, FULL, STREAM} state_t;

    state_t                   state_q;
    logic [AW-1:0]            wr_cnt_q;
    logic [AW-1:0]            orow_q, ocol_q, kr_q, kc_q;
    logic [AW-1:0]            orow_d, ocol_d, kr_d, kc_d;
    logic [DATA_BITWIDTH-1:0] iact_out_q;
    logic                     iact_valid_q, win_last_q, load_done_q, conv_done_q;
    logic [DATA_BITWIDTH-1:0] mem [2**AW];

    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic          last_elem;
    logic          xfer;

    // The strobe arriving in the load_done cycle is the router's trailing strobe,
    // so it must not start a reload.
    always_comb begin
        we    = 1'b0;
        waddr = wr_cnt_q;
        case (state_q)
            IDLE: begin
                we    = load_en_spad;
                waddr = '0;
            end
            LOADING: we = load_en_spad;
            FULL: begin
                we    = load_en_spad & ~start_conv & ~load_done_q;
                waddr = '0;
            end
            default: we = 1'b0;
        endcase
    end

    always_comb begin
        orow_d = orow_q;
        ocol_d = ocol_q;
        kr_d   = kr_q;
        kc_d   = kc_q;
        if (kc_q != KM1) begin
            kc_d = kc_q + 1'b1;
        end else begin
            kc_d = '0;
            if (kr_q != KM1) begin
                kr_d = kr_q + 1'b1;
            end else begin
                kr_d = '0;
                if (ocol_q != OM1) begin
                    ocol_d = ocol_q + 1'b1;
                end else begin
                    ocol_d = '0;
                    orow_d = orow_q + 1'b1;
                end
            end
        end
        last_elem = (orow_q == OM1) && (ocol_q == OM1) && (kr_q == KM1) && (kc_q == KM1);
        raddr     = (orow_d + kr_d) * ACT_A + ocol_d + kc_d;
        xfer      = iact_valid_q & iact_ready;
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= w_data_spad;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_cnt_q     <= '0;
            orow_q       <= '0;
            ocol_q       <= '0;
            kr_q         <= '0;
            kc_q         <= '0;
            iact_out_q   <= '0;
            iact_valid_q <= 1'b0;
            win_last_q   <= 1'b0;
            load_done_q  <= 1'b0;
            conv_done_q  <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            conv_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_en_spad) begin
                        wr_cnt_q <= AW'(1);
                        state_q  <= LOADING;
                    end
                end
                LOADING: begin
                    if (load_en_spad) begin
                        if (wr_cnt_q == NM1) begin
                            wr_cnt_q    <= '0;
                            load_done_q <= 1'b1;
                            state_q     <= FULL;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (start_conv) begin
                        orow_q       <= '0;
                        ocol_q       <= '0;
                        kr_q         <= '0;
                        kc_q         <= '0;
                        iact_out_q   <= mem[0];
                        iact_valid_q <= 1'b1;
                        win_last_q   <= (KM1 == '0);
                        state_q      <= STREAM;
                    end else if (we) begin
                        wr_cnt_q <= AW'(1);
                        state_q  <= LOADING;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (last_elem) begin
                            iact_valid_q <= 1'b0;
                            win_last_q   <= 1'b0;
                            conv_done_q  <= 1'b1;
                            state_q      <= FULL;
                        end else begin
                            orow_q     <= orow_d;
                            ocol_q     <= ocol_d;
                            kr_q       <= kr_d;
                            kc_q       <= kc_d;
                            iact_out_q <= mem[raddr];
                            win_last_q <= (kr_d == KM1) && (kc_d == KM1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign iact_out   = iact_out_q;
    assign iact_valid = iact_valid_q;
    assign win_last   = win_last_q;
    assign load_done  = load_done_q;
    assign conv_done  = conv_done_q;
    assign busy       = (state_q == LOADING) || (state_q == STREAM);

endmodule

// File: tb/tb_spad_iact_window.sv
// Bench for spad_iact_window: expected windows are built from a 2-D plane model,
// with random backpressure and stray strobes layered on directed steps.
module tb_spad_iact_window;

    localparam int DW    = 16;
    localparam int AS    = 5;
    localparam int KS    = 3;
    localparam int OS    = AS - KS + 1;
    localparam int N     = AS * AS;
    localparam int TOTAL = OS * OS * KS * KS;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] w_data_spad;
    logic          load_en_spad;
    logic          load_done;
    logic          start_conv;
    logic [DW-1:0] iact_out;
    logic          iact_valid;
    logic          iact_ready;
    logic          win_last;
    logic          conv_done;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int plane [AS][AS];
    int exp_q [$];

    spad_iact_window #(
        .DATA_BITWIDTH(DW),
        .ADDR_BITWIDTH_SPAD(9),
        .act_size(AS),
        .kernel_size(KS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .w_data_spad(w_data_spad),
        .load_en_spad(load_en_spad),
        .load_done(load_done),
        .start_conv(start_conv),
        .iact_out(iact_out),
        .iact_valid(iact_valid),
        .iact_ready(iact_ready),
        .win_last(win_last),
        .conv_done(conv_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Window sequence: output rows, output cols, then each window row-major.
    task automatic build_expected();
        exp_q.delete();
        for (int orow = 0; orow < OS; orow++)
            for (int ocol = 0; ocol < OS; ocol++)
                for (int kr = 0; kr < KS; kr++)
                    for (int kc = 0; kc < KS; kc++)
                        exp_q.push_back(plane[orow + kr][ocol + kc]);
    endtask

    task automatic load_plane(input int base, input bit gaps, input bit trailing);
        int i   = 0;
        int cyc = 0;
        while (i < N && cyc < 500) begin
            cyc++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                load_en_spad = 1'b0;
                start_conv   = 1'b1;
                tick();
                check("start_ignored_valid", iact_valid, 0);
                check("gap_busy", busy, i > 0);
                check("gap_load_done", load_done, 0);
                start_conv = 1'b0;
            end else begin
                load_en_spad = 1'b1;
                w_data_spad  = DW'(base + i);
                plane[i / AS][i % AS] = base + i;
                tick();
                i++;
                check("load_done", load_done, i == N);
                check("busy_load", busy, i < N);
            end
        end
        check("load_count", i, N);
        load_en_spad = 1'b0;
        start_conv   = 1'b0;
        if (trailing) begin
            load_en_spad = 1'b1;
            w_data_spad  = 16'd999;
        end
        tick();
        load_en_spad = 1'b0;
        check("load_done_once", load_done, 0);
        check("busy_full", busy, 0);
        check("valid_after_load", iact_valid, 0);
        build_expected();
    endtask

    task automatic run_stream(input int ready_pct, input bit strobes, input bit with_load,
                              input int abort_at);
        int            n       = 0;
        int            cyc     = 0;
        bit            stalled = 1'b0;
        logic [DW-1:0] prev_out;
        logic          prev_last;
        start_conv = 1'b1;
        if (with_load) begin
            load_en_spad = 1'b1;
            w_data_spad  = 16'd7777;
        end
        iact_ready = 1'b0;
        tick();
        start_conv   = 1'b0;
        load_en_spad = 1'b0;
        check("first_valid", iact_valid, 1);
        check("busy_stream", busy, 1);
        while (n < TOTAL) begin
            cyc++;
            if (cyc > 4000) begin
                check("stream_timeout", n, TOTAL);
                break;
            end
            check("valid", iact_valid, 1);
            check("data", iact_out, exp_q[n]);
            check("win_last", win_last, (n % (KS * KS)) == KS * KS - 1);
            check("conv_done_early", conv_done, 0);
            if (stalled) begin
                check("hold_data", iact_out, prev_out);
                check("hold_last", win_last, prev_last);
            end
            prev_out   = iact_out;
            prev_last  = win_last;
            iact_ready = ($urandom_range(0, 99) < ready_pct);
            if (strobes) begin
                load_en_spad = 1'($urandom_range(0, 1));
                w_data_spad  = 16'd999;
            end
            stalled = !iact_ready;
            tick();
            if (iact_ready) n++;
            if (abort_at >= 0 && n == abort_at) begin
                load_en_spad = 1'b0;
                iact_ready   = 1'b0;
                #2 reset = 1'b1;
                #1;
                check("abort_valid", iact_valid, 0);
                check("abort_data", iact_out, 0);
                check("abort_last", win_last, 0);
                check("abort_busy", busy, 0);
                check("abort_conv_done", conv_done, 0);
                @(posedge clk);
                #1 reset = 1'b0;
                tick();
                check("abort_idle_valid", iact_valid, 0);
                check("abort_idle_conv_done", conv_done, 0);
                return;
            end
        end
        load_en_spad = 1'b0;
        check("conv_done", conv_done, 1);
        check("valid_drop", iact_valid, 0);
        check("busy_after", busy, 0);
        tick();
        check("conv_done_pulse", conv_done, 0);
        check("valid_stays_low", iact_valid, 0);
    endtask

    initial begin
        reset        = 1'b1;
        w_data_spad  = '0;
        load_en_spad = 1'b0;
        start_conv   = 1'b0;
        iact_ready   = 1'b0;
        #1;
        check("rst_valid", iact_valid, 0);
        check("rst_data", iact_out, 0);
        check("rst_last", win_last, 0);
        check("rst_load_done", load_done, 0);
        check("rst_conv_done", conv_done, 0);
        check("rst_busy", busy, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        start_conv = 1'b1;
        tick();
        tick();
        check("idle_start_valid", iact_valid, 0);
        check("idle_start_busy", busy, 0);
        start_conv = 1'b0;
        tick();

        load_plane(100, 1'b0, 1'b1);
        run_stream(100, 1'b0, 1'b0, -1);
        run_stream(50, 1'b0, 1'b0, -1);
        run_stream(100, 1'b1, 1'b0, -1);
        run_stream(70, 1'b1, 1'b0, -1);
        run_stream(100, 1'b0, 1'b1, -1);
        run_stream(100, 1'b0, 1'b1, -1);
        run_stream(100, 1'b0, 1'b0, 40);

        load_plane(200, 1'b1, 1'b0);
        run_stream(100, 1'b0, 1'b0, -1);
        run_stream(50, 1'b1, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spad_iact_window.md
Name: spad_iact_window

Overview:
- Per-PE input-activation scratchpad. It sits directly downstream of the iact GLB router.
- Captures the act_size×act_size activation plane that the router streams in via w_data_spad/load_en_spad.
- Replays the plane as kernel_size×kernel_size sliding windows (stride 1, row-major) to the MAC datapath over a valid/ready handshake.
- Data is retained after a pass, so the same plane can be replayed without a reload.

Parameters:
- DATA_BITWIDTH, 16, activation word width
- ADDR_BITWIDTH_SPAD, 9, internal address width; act_size**2 must be ≤ 2**ADDR_BITWIDTH_SPAD
- act_size, 5, input plane edge length (N = act_size**2 words)
- kernel_size, 3, window edge length (K); output edge O = act_size-kernel_size+1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- w_data_spad  in  DATA_BITWIDTH  activation word from router
- load_en_spad  in  1  write strobe; one word per cycle while high
- load_done  out  1  one-cycle pulse: N words captured
- start_conv  in  1  request one full window pass; honoured only in FULL
- iact_out  out  DATA_BITWIDTH  windowed activation
- iact_valid  out  1  iact_out valid
- iact_ready  in  1  consumer accepts iact_out
- win_last  out  1  qualifies iact_out as the last element (kr=kc=K-1) of a window
- conv_done  out  1  one-cycle pulse after the final element of the pass is accepted
- busy  out  1  high in LOADING or STREAM

Behaviour:
- Reset (async, active-high):
  - state=IDLE; wr_cnt, orow, ocol, kr, kc=0.
  - All outputs 0.
  - Memory contents are don't-care.
  - Reset mid-load or mid-stream abandons the operation; no conv_done or load_done is generated.
- State IDLE:
  - load_en_spad=1 writes mem[0], sets wr_cnt=1, goes to LOADING.
  - start_conv is ignored.
- State LOADING:
  - Each cycle with load_en_spad=1 writes mem[wr_cnt] and increments wr_cnt.
  - Cycles with load_en_spad=0 are gaps: no write, stay in LOADING.
  - The write with wr_cnt=N-1 goes to FULL, resets wr_cnt to 0, and pulses load_done on the following cycle.
- State FULL:
  - start_conv=1 goes to STREAM with counters at 0.
  - Otherwise load_en_spad=1 starts a reload: writes mem[0], wr_cnt=1, goes to LOADING.
  - start_conv and load_en_spad in the same cycle: start_conv wins and the word is dropped.
- Write protection: load_en_spad in STREAM, and any write strobes beyond N, are ignored. The router's trailing strobe therefore cannot corrupt data.
- State STREAM addressing:
  - Read address = (orow+kr)*act_size + (ocol+kc), computed in ADDR_BITWIDTH_SPAD bits.
  - Loop order, innermost first: kc, kr, ocol, orow; each loop counts 0..K-1 or 0..O-1.
- Output register and latency:
  - First iact_valid appears in the cycle after start_conv is sampled.
  - iact_out, iact_valid and win_last are registered.
- Handshake:
  - A transfer occurs when iact_valid & iact_ready.
  - On a transfer, the next element is presented the next cycle; there are no bubbles while iact_ready=1.
  - While iact_valid=1 and iact_ready=0, iact_out and win_last hold stable.
- End of pass:
  - Transfer of the element with orow=ocol=O-1 and kr=kc=K-1: iact_valid drops the next cycle, conv_done pulses in that same cycle, state returns to FULL.
  - Total transfers per pass = O*O*K*K (81 with defaults).
- Replay: a subsequent start_conv in FULL replays the identical sequence.
- busy=1 in LOADING and STREAM, 0 otherwise.

Test Plan:
1. Reset, then 25 consecutive load_en_spad cycles with data 100..124 -> load_done pulses exactly once, one cycle after the 25th write; busy=1 during load, 0 after.
2. start_conv with iact_ready=1 -> first 9 outputs 100,101,102,105,106,107,110,111,112, win_last on 112; second window begins 101; 81st output 124 with win_last; conv_done one cycle later; no gaps.
3. Random iact_ready backpressure (~50%) -> same 81-word sequence; iact_out stable on every stalled cycle; conv_done only after the 81st transfer.
4. A 26th load_en_spad strobe (data 999) right after load, plus strobes during STREAM -> ignored; stream output identical to scenario 2; a second start_conv replays it.
5. start_conv in IDLE and LOADING -> no iact_valid. Simultaneous start_conv+load_en_spad in FULL -> stream starts and the word is dropped.
6. Assert reset mid-stream (after output 40) -> outputs 0 immediately (asynchronously), state IDLE; reload 200..224 and stream -> first window 200,201,202,205,...
